// File: rtl/scope_readout_pkg.sv
// Shared types and defaults for the logic-analyzer capture-buffer readout engine.
package scope_readout_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam logic [7:0] READOUT_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_HDR   = 3'd2,
        S_FETCH = 3'd3,
        S_LOAD  = 3'd4,
        S_SEND  = 3'd5
    } state_e;

    // States in which a falling i_stopped cancels the dump.
    function automatic logic is_dump_state(input state_e s);
        return (s == S_HDR) || (s == S_FETCH) || (s == S_LOAD) || (s == S_SEND);
    endfunction

endpackage

// File: rtl/scope_readout_word_serializer.sv
// Holds one sample and hands it out a byte at a time, least significant byte first.
module scope_readout_word_serializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic [7:0]            o_byte_next,
    output logic                  o_last
);
    localparam int NBYTES = (DATA_WIDTH + 7) / 8;
    localparam int SW     = NBYTES * 8;
    localparam int CW     = $clog2(NBYTES + 1);

    logic [SW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (i_load) begin
            shreg_d = SW'(i_data);
            cnt_d   = '0;
        end else if (i_shift) begin
            shreg_d = shreg_q >> 8;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Exposing the next low byte lets the parent register o_tx_data in step with the shift.
    assign o_byte_next = shreg_d[7:0];
    assign o_last      = (cnt_q == CW'(NBYTES - 1));

endmodule

// File: rtl/scope_readout.sv
// Replays the frozen capture buffer oldest-first as a header byte followed by
// every sample serialized LSB-first onto a valid/ready byte stream.
module scope_readout
    import scope_readout_pkg::*;
#(
    parameter int         DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int         ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [7:0] HEADER     = READOUT_HEADER
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_stopped,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_abort
);
    localparam logic [ADDR_WIDTH:0] LAST_WORD = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;

    logic                  hs;
    logic                  ser_load, ser_shift, ser_last;
    logic [7:0]            ser_byte;

    scope_readout_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_load      (ser_load),
        .i_data      (i_rdata),
        .i_shift     (ser_shift),
        .o_byte_next (ser_byte),
        .o_last      (ser_last)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        wcnt_d    = wcnt_q;
        raddr_d   = raddr_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        hs        = tx_valid_q && i_tx_ready;

        if (is_dump_state(state_q) && !i_stopped) begin
            abort_d = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (i_start) state_d = S_ARM;
                S_ARM: begin
                    if (i_stopped) begin
                        base_d  = i_waddr;
                        wcnt_d  = '0;
                        state_d = S_HDR;
                    end
                end
                S_HDR:   if (hs) state_d = S_FETCH;
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    ser_load = 1'b1;
                    state_d  = S_SEND;
                end
                S_SEND: begin
                    if (hs) begin
                        ser_shift = 1'b1;
                        if (ser_last) begin
                            if (wcnt_q == LAST_WORD) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                wcnt_d  = wcnt_q + (ADDR_WIDTH + 1)'(1);
                                state_d = S_FETCH;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // FETCH lasts one cycle, so the address only moves on entry to it.
        if (state_d == S_FETCH) raddr_d = base_q + wcnt_d[ADDR_WIDTH-1:0];

        tx_valid_d = (state_d == S_HDR) || (state_d == S_SEND);
        tx_data_d  = tx_data_q;
        if (state_d == S_HDR)       tx_data_d = HEADER;
        else if (state_d == S_SEND) tx_data_d = ser_byte;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            wcnt_q     <= '0;
            raddr_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wcnt_q     <= wcnt_d;
            raddr_q    <= raddr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign o_raddr    = raddr_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_abort    = abort_q;

endmodule

// File: tb/tb_scope_readout.sv
// Bench for scope_readout: table-driven dumps, randomized backpressure/bases, abort and reset corners.
module tb_scope_readout;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NB    = 2;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset;
    logic          i_start;
    logic          i_stopped;
    logic [AW-1:0] i_waddr;
    logic [AW-1:0] o_raddr;
    logic [DW-1:0] i_rdata;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_abort;

    scope_readout #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .HEADER     (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_stopped  (i_stopped),
        .i_waddr    (i_waddr),
        .o_raddr    (o_raddr),
        .i_rdata    (i_rdata),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_abort    (o_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture memory: one-cycle read latency, contents C000 | address.
    always_ff @(posedge clk) i_rdata <= 16'hC000 | 16'(o_raddr);

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int  first_valid, done_at, abort_at, last_hs, drop_cyc;
    int  done_cnt, abort_cnt, stall_bad, busy_bad, post_bad;
    bit  valid_at_abort, busy_at_abort, ended;

    typedef struct {
        logic [AW-1:0] base;
        int            mode;       // 0: ready high, 1: 1-high/2-low, 2: random
        int            stop_delay; // cycle at which i_stopped rises (0: already high)
        bit            extra_start;
        int            exp_first;
        int            exp_done;   // -1 when backpressure makes it pattern dependent
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint actual, input longint required);
        n_checks++;
        if (actual == required) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
    endtask

    // Reference stream: header, then every word oldest-first, each LSB byte first.
    function automatic void build_expected(input logic [AW-1:0] base);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int w = 0; w < DEPTH; w++) begin
            int unsigned sample;
            sample = 32'hC000 | ((int'(base) + w) % DEPTH);
            for (int b = 0; b < NB; b++) exp_q.push_back(8'((sample >> (8 * b)) & 32'hFF));
        end
    endfunction

    function automatic int first_diff(input int n);
        for (int i = 0; i < n; i++)
            if (i >= exp_q.size() || got[i] != exp_q[i]) return i;
        return -1;
    endfunction

    // Cycle 0 is the cycle in which i_start is high; inputs change and outputs are read at negedge.
    task automatic run_dump(input logic [AW-1:0] base, input int mode, input int stop_delay,
                            input int abort_bytes, input int reset_bytes, input bit extra_start);
        bit stalled, finished;
        logic [7:0] stall_byte;
        int tail;
        got.delete();
        first_valid = -1; done_at = -1; abort_at = -1; last_hs = -1; drop_cyc = -1;
        done_cnt = 0; abort_cnt = 0; stall_bad = 0; busy_bad = 0; post_bad = 0;
        valid_at_abort = 1'b0; busy_at_abort = 1'b0; ended = 1'b0;
        stalled = 1'b0; finished = 1'b0; stall_byte = 8'h00; tail = 0;
        i_waddr   = base;
        i_stopped = (stop_delay == 0);
        for (int c = 0; c < 800; c++) begin
            i_start = (c == 0) || (extra_start && o_tx_valid && got.size() == 5);
            if (c == stop_delay) i_stopped = 1'b1;
            if (abort_bytes >= 0 && drop_cyc < 0 && o_tx_valid && got.size() == abort_bytes) begin
                i_stopped = 1'b0;
                drop_cyc  = c;
            end
            case (mode)
                0:       i_tx_ready = 1'b1;
                1:       i_tx_ready = (c % 3 == 0);
                default: i_tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            reset = (reset_bytes >= 0 && o_tx_valid && got.size() == reset_bytes);

            if (stalled && o_tx_valid && o_tx_data != stall_byte) stall_bad++;
            if (o_tx_valid && first_valid < 0) first_valid = c;
            if (o_done) begin done_cnt++; done_at = c; end
            if (o_abort) begin
                abort_cnt++; abort_at = c;
                valid_at_abort = o_tx_valid; busy_at_abort = o_busy;
            end
            if (finished && (o_tx_valid || o_busy)) post_bad++;
            if (!finished && c >= 1 && !o_busy && !o_done && !o_abort) busy_bad++;
            if ((o_done || o_abort) && o_busy) busy_bad++;
            if (o_tx_valid && i_tx_ready) begin got.push_back(o_tx_data); last_hs = c; end
            stalled    = o_tx_valid && !i_tx_ready;
            stall_byte = o_tx_data;
            if (o_done || o_abort) finished = 1'b1;
            if (finished) tail++;

            @(negedge clk);
            if (reset) begin
                check("reset_mid_send_outputs",
                      {o_tx_valid, o_busy, o_done, o_abort, o_tx_data, o_raddr}, 0);
                reset = 1'b0;
                ended = 1'b1;
                break;
            end
            if (tail == 8) begin ended = 1'b1; break; end
        end
        i_start = 1'b0;
        check("dump_ended_within_budget", ended, 1);
        $display("dump base=%0d mode=%0d stop=%0d bytes=%0d first_valid=%0d done_at=%0d abort_at=%0d",
                 base, mode, stop_delay, got.size(), first_valid, done_at, abort_at);
    endtask

    task automatic check_full(input logic [AW-1:0] base, input int exp_first, input int exp_done);
        build_expected(base);
        check("byte_count", got.size(), exp_q.size());
        check("byte_first_mismatch_index", first_diff(got.size()), -1);
        check("first_valid_cycle", first_valid, exp_first);
        if (exp_done >= 0) check("done_cycle", done_at, exp_done);
        check("done_after_last_byte", done_at, last_hs + 1);
        check("done_pulses", done_cnt, 1);
        check("abort_pulses", abort_cnt, 0);
        check("data_change_while_stalled", stall_bad, 0);
        check("busy_glitches", busy_bad, 0);
        check("activity_after_done", post_bad, 0);
    endtask

    initial begin
        // Full-speed dump length: 2 to header, 1 header, DEPTH*(NB+2) data cycles.
        vecs[0] = '{base: 4'd5,  mode: 0, stop_delay: 0,  extra_start: 1'b0, exp_first: 2,  exp_done: 67};
        vecs[1] = '{base: 4'd5,  mode: 1, stop_delay: 0,  extra_start: 1'b0, exp_first: 2,  exp_done: -1};
        vecs[2] = '{base: 4'd0,  mode: 0, stop_delay: 10, extra_start: 1'b0, exp_first: 11, exp_done: 76};
        vecs[3] = '{base: 4'd15, mode: 0, stop_delay: 0,  extra_start: 1'b0, exp_first: 2,  exp_done: 67};
        vecs[4] = '{base: 4'd2,  mode: 0, stop_delay: 0,  extra_start: 1'b1, exp_first: 2,  exp_done: 67};
        vecs[5] = '{base: 4'd9,  mode: 1, stop_delay: 3,  extra_start: 1'b0, exp_first: 4,  exp_done: -1};

        reset = 1'b1; i_start = 1'b0; i_stopped = 1'b1; i_waddr = '0; i_tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state_outputs", {o_tx_valid, o_busy, o_done, o_abort, o_tx_data, o_raddr}, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_dump(vecs[i].base, vecs[i].mode, vecs[i].stop_delay, -1, -1, vecs[i].extra_start);
            check_full(vecs[i].base, vecs[i].exp_first, vecs[i].exp_done);
        end

        for (int r = 0; r < 4; r++) begin
            logic [AW-1:0] base;
            int stop;
            base = AW'($urandom_range(0, DEPTH - 1));
            stop = $urandom_range(0, 6);
            run_dump(base, 2, stop, -1, -1, 1'b0);
            check_full(base, (stop <= 1) ? 2 : stop + 1, -1);
        end

        // Cancel while word 3's first byte is on the stream.
        run_dump(4'd5, 0, 0, 1 + 3 * NB, -1, 1'b0);
        build_expected(4'd5);
        check("abort_pulses", abort_cnt, 1);
        check("abort_cycle", abort_at, drop_cyc + 1);
        check("abort_valid_dropped", valid_at_abort, 0);
        check("abort_busy_low", busy_at_abort, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_prefix_mismatch_index", first_diff(got.size()), -1);
        check("abort_bytes_reached_word3", got.size() >= 1 + 3 * NB, 1);
        check("activity_after_abort", post_bad, 0);
        i_stopped = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of SEND, then a fresh complete dump.
        run_dump(4'd5, 0, 0, -1, 10, 1'b0);
        repeat (2) @(negedge clk);
        run_dump(4'd5, 0, 0, -1, -1, 1'b0);
        check_full(4'd5, 2, 67);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
